// File: rtl/ps2_key_event_scheduler.sv
// rtl/ps2_key_event_scheduler.sv - PS/2 scan-code parser with held-key bitmap and event FIFO
module ps2_key_event_scheduler #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [7:0]               byte_data,
  input  logic                     byte_valid,
  output logic [7:0]               held,
  output logic                     evt_valid,
  output logic [2:0]               evt_key,
  output logic                     evt_make,
  input  logic                     evt_ready,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    P_IDLE    = 2'd0,
    P_EXT     = 2'd1,
    P_BRK     = 2'd2,
    P_EXT_BRK = 2'd3
  } pstate_t;

  pstate_t        r_state;
  pstate_t        w_state_nxt;
  logic [TW-1:0]  r_tcnt;
  logic [7:0]     r_held;
  logic [7:0]     w_held_nxt;
  logic           w_map_hit;
  logic [2:0]     w_map_idx;
  logic           w_is_make;
  logic           w_is_break;
  logic           w_push;
  logic           w_push_ok;
  logic           w_pop;
  logic [3:0]     r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [CW-1:0]  r_count;
  logic           r_ovf;

  // Map the incoming byte to one of the eight game keys
  always_comb begin
    w_map_hit = 1'b1;
    w_map_idx = 3'd0;
    case (byte_data)
      8'h23: w_map_idx = 3'd0;
      8'h2B: w_map_idx = 3'd1;
      8'h3B: w_map_idx = 3'd2;
      8'h42: w_map_idx = 3'd3;
      8'h5A: w_map_idx = 3'd4;
      8'h76: w_map_idx = 3'd5;
      8'h16: w_map_idx = 3'd6;
      8'h1E: w_map_idx = 3'd7;
      default: w_map_hit = 1'b0;
    endcase
  end

  // Parser state register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= P_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Parser next state and make/break decode; a stalled prefix falls back to idle
  always_comb begin
    w_state_nxt = r_state;
    w_is_make   = 1'b0;
    w_is_break  = 1'b0;
    if (byte_valid) begin
      case (r_state)
        P_IDLE: begin
          if (byte_data == 8'hE0)      w_state_nxt = P_EXT;
          else if (byte_data == 8'hF0) w_state_nxt = P_BRK;
          else if (w_map_hit)          w_is_make   = 1'b1;
        end
        P_EXT: begin
          if (byte_data == 8'hF0) w_state_nxt = P_EXT_BRK;
          else                    w_state_nxt = P_IDLE;
        end
        P_BRK: begin
          w_is_break  = w_map_hit;
          w_state_nxt = P_IDLE;
        end
        default: w_state_nxt = P_IDLE;
      endcase
    end else if (r_state != P_IDLE && r_tcnt == TMAX) begin
      w_state_nxt = P_IDLE;
    end
  end

  // Prefix timeout counter: runs only while waiting for the rest of a sequence
  always_ff @(posedge clk) begin
    if (!resetn)
      r_tcnt <= '0;
    else if (byte_valid || r_state == P_IDLE || r_tcnt == TMAX)
      r_tcnt <= '0;
    else
      r_tcnt <= r_tcnt + TW'(1);
  end

  // Edge detection against the held bitmap suppresses typematic repeats and stray breaks
  always_comb begin
    w_held_nxt = r_held;
    w_push     = (w_is_make && !r_held[w_map_idx]) || (w_is_break && r_held[w_map_idx]);
    if (w_push) w_held_nxt[w_map_idx] = w_is_make;
  end

  // Held bitmap tracks physical key state even if the event is dropped
  always_ff @(posedge clk) begin
    if (!resetn) r_held <= '0;
    else         r_held <= w_held_nxt;
  end

  assign w_pop     = (r_count != '0) && evt_ready;
  assign w_push_ok = w_push && ((r_count != FULL) || w_pop);

  // Event storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= {w_map_idx, w_is_make};
  end

  // FIFO pointers, occupancy and overflow pulse
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + AW'(1);
      if (w_pop)     r_rd <= r_rd + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_ovf <= w_push && !w_push_ok;
    end
  end

  assign held      = r_held;
  assign evt_valid = (r_count != '0);
  assign evt_key   = r_mem[r_rd][3:1];
  assign evt_make  = r_mem[r_rd][0];
  assign evt_count = r_count;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_ps2_key_event_scheduler.sv
// tb/tb_ps2_key_event_scheduler.sv - directed self-checking bench for ps2_key_event_scheduler
module tb_ps2_key_event_scheduler;

  logic       clk;
  logic       resetn;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic [7:0] held;
  logic       evt_valid;
  logic [2:0] evt_key;
  logic       evt_make;
  logic       evt_ready;
  logic [2:0] evt_count;
  logic       overflow;

  int n_total;
  int n_bad;

  ps2_key_event_scheduler #(
    .DEPTH(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .byte_data(byte_data),
    .byte_valid(byte_valid),
    .held(held),
    .evt_valid(evt_valid),
    .evt_key(evt_key),
    .evt_make(evt_make),
    .evt_ready(evt_ready),
    .evt_count(evt_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag, input logic [2:0] k, input logic m);
    chk({tag, "_valid"}, evt_valid, 1'b1);
    chk({tag, "_key"}, evt_key, k);
    chk({tag, "_make"}, evt_make, m);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    resetn     = 1'b0;
    byte_data  = 8'h00;
    byte_valid = 1'b0;
    evt_ready  = 1'b0;
    @(negedge clk);
    do_reset();

    chk("rst_held", held, 8'h00);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_count", evt_count, 3'd0);
    chk("rst_ovf", overflow, 1'b0);

    // pop while empty is ignored
    evt_ready = 1'b1;
    idle(1);
    evt_ready = 1'b0;
    chk("empty_pop_count", evt_count, 3'd0);

    // typematic repeats then release
    send(8'h23);
    chk("typ_held1", held, 8'h01);
    chk("typ_count1", evt_count, 3'd1);
    send(8'h23);
    send(8'h23);
    chk("typ_count_rep", evt_count, 3'd1);
    send(8'hF0);
    chk("typ_held_pre", held, 8'h01);
    send(8'h23);
    chk("typ_held0", held, 8'h00);
    chk("typ_count2", evt_count, 3'd2);
    pop_chk("typ_e0", 3'd0, 1'b1);
    pop_chk("typ_e1", 3'd0, 1'b0);
    chk("typ_empty", evt_valid, 1'b0);

    // push while empty with ready high: no bypass
    byte_data  = 8'h2B;
    byte_valid = 1'b1;
    evt_ready  = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    evt_ready  = 1'b0;
    chk("nobypass_count", evt_count, 3'd1);
    pop_chk("nobypass_e", 3'd1, 1'b1);

    // chord on back-to-back strobes
    do_reset();
    send(8'h23);
    chk("chord_h1", held, 8'h01);
    send(8'h3B);
    chk("chord_h2", held, 8'h05);
    send(8'hF0);
    send(8'h23);
    chk("chord_h3", held, 8'h04);
    send(8'hF0);
    send(8'h3B);
    chk("chord_h4", held, 8'h00);
    chk("chord_count", evt_count, 3'd4);
    pop_chk("chord_e0", 3'd0, 1'b1);
    pop_chk("chord_e1", 3'd2, 1'b1);
    pop_chk("chord_e2", 3'd0, 1'b0);
    pop_chk("chord_e3", 3'd2, 1'b0);

    // extended and unmapped codes produce nothing
    do_reset();
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h1C);
    send(8'hF0); send(8'h1C);
    chk("ext_count", evt_count, 3'd0);
    chk("ext_held", held, 8'h00);
    send(8'h42);
    chk("ext_after_held", held, 8'h08);
    pop_chk("ext_after_e", 3'd3, 1'b1);

    // overflow
    do_reset();
    send(8'h23); send(8'h2B); send(8'h3B); send(8'h42);
    chk("ovf_count4", evt_count, 3'd4);
    chk("ovf_none", overflow, 1'b0);
    send(8'h5A);
    chk("ovf_pulse", overflow, 1'b1);
    chk("ovf_count", evt_count, 3'd4);
    chk("ovf_held", held, 8'h1F);
    idle(1);
    chk("ovf_one_cycle", overflow, 1'b0);
    byte_data  = 8'h76;
    byte_valid = 1'b1;
    evt_ready  = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    evt_ready  = 1'b0;
    chk("full_pp_count", evt_count, 3'd4);
    chk("full_pp_ovf", overflow, 1'b0);
    chk("full_pp_held", held, 8'h3F);
    pop_chk("full_e0", 3'd1, 1'b1);
    pop_chk("full_e1", 3'd2, 1'b1);
    pop_chk("full_e2", 3'd3, 1'b1);
    pop_chk("full_e3", 3'd5, 1'b1);
    chk("full_empty", evt_count, 3'd0);

    // reset discards queued events
    send(8'h16);
    do_reset();
    chk("rst_q_count", evt_count, 3'd0);
    chk("rst_q_held", held, 8'h00);

    // timeout abandons the break prefix
    send(8'hF0);
    idle(16);
    send(8'h23);
    chk("to16_held", held, 8'h01);
    pop_chk("to16_e", 3'd0, 1'b1);

    // short gap keeps the prefix: break of an unheld key
    do_reset();
    send(8'hF0);
    idle(10);
    send(8'h23);
    chk("to10_count", evt_count, 3'd0);
    chk("to10_held", held, 8'h00);

    // reset during break prefix
    send(8'hF0);
    do_reset();
    send(8'h23);
    chk("rstbrk_held", held, 8'h01);
    pop_chk("rstbrk_e", 3'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_scheduler.md
Name: ps2_key_event_scheduler

Overview:
- Sits between the PS/2 receiver (byte + one-cycle valid) and the game logic.
- Parses the scan-code stream (make, F0 break prefix, E0 extended prefix) into a held-key bitmap for the 8 game keys.
- Queues press and release events in a FIFO, popped by the game with a valid/ready handshake.
- Unlike a single-key FSM, it tracks simultaneous holds (chords across D/F/J/K) and suppresses typematic repeats.

Parameters:
DEPTH, 4, event FIFO depth; power of two, >= 2
TIMEOUT_CYCLES, 1000000, cycles (20 ms at 50 MHz) a prefix state waits for the next byte before abandoning the sequence

Ports:
clk  in  1  system clock (50 MHz)
resetn  in  1  synchronous, active-low reset
byte_data  in  8  scan-code byte from PS/2 receiver
byte_valid  in  1  one-cycle strobe; byte_data valid this cycle
held  out  8  current held bitmap: [0]D(23) [1]F(2B) [2]J(3B) [3]K(42) [4]Enter(5A) [5]Esc(76) [6]'1'(16) [7]'2'(1E)
evt_valid  out  1  FIFO head valid
evt_key  out  3  key index of head event
evt_make  out  1  1 = press, 0 = release
evt_ready  in  1  consumer pop; pop occurs when evt_valid & evt_ready
evt_count  out  clog2(DEPTH)+1  events currently queued
overflow  out  1  one-cycle pulse when an event is dropped because the FIFO is full

Behaviour:
- Reset (resetn=0 at a clk edge): parser to P_IDLE, timeout counter 0, held=0, FIFO emptied (evt_valid=0, evt_count=0), overflow=0. Reset mid-sequence discards any pending prefix and all queued events.
- Parser FSM, advanced only on byte_valid:
  - P_IDLE: E0 -> P_EXT; F0 -> P_BRK; mapped code -> make(k), stay; any other byte -> ignored, stay.
  - P_EXT: F0 -> P_EXT_BRK; any other byte -> P_IDLE, no event (extended codes are not game keys).
  - P_BRK: mapped code -> break(k), P_IDLE; any other byte -> P_IDLE, no event.
  - P_EXT_BRK: any byte -> P_IDLE, no event.
- Timeout: in any non-IDLE state the counter increments each cycle without byte_valid. On reaching TIMEOUT_CYCLES-1 the FSM returns to P_IDLE and the counter clears. The counter also clears on every byte_valid and whenever the FSM is in P_IDLE.
- make(k):
  - If held[k]=0: set held[k] at the next edge and push {k,1}.
  - If held[k]=1 (typematic repeat): no change, no push.
- break(k):
  - If held[k]=1: clear held[k] and push {k,0}.
  - If held[k]=0: ignore.
- held is updated even when the push is dropped, so the bitmap always reflects the physical key state.
- Latency: a byte accepted at edge N updates held and the FIFO at edge N. With an empty FIFO, evt_valid=1 and the event appear in the cycle after the strobe (1-cycle latency). Head is show-ahead: evt_key/evt_make are valid whenever evt_valid=1.
- FIFO: circular buffer, DEPTH entries, pointers wrap modulo DEPTH. evt_count is exact.
  - Push with count=DEPTH and no pop in the same cycle: event dropped; overflow=1 for exactly one cycle.
  - Push and pop in the same cycle while full: both occur; count stays DEPTH; no overflow.
  - Push and pop in the same cycle while empty: only the push takes effect (no bypass); count becomes 1.
  - Pop while empty: ignored.
  - evt_key/evt_make are don't-care when evt_valid=0; the bench must not check them then.
- byte_valid is at most one cycle wide per byte. Consecutive-cycle strobes must each be processed (no back-pressure to the receiver).

Test Plan:
- resetn=0 for 2 cycles -> held=00, evt_valid=0, evt_count=0, overflow=0.
- Bytes 23, 23, 23 (typematic), then F0 23, evt_ready=1 -> exactly two events popped: {0,1} then {0,0}; held[0]=1 after the first byte, 0 after the 23 that follows F0.
- Chord: bytes 23, 3B, F0 23, F0 3B on back-to-back cycles, evt_ready=0 -> evt_count=4, held sequence 01 -> 05 -> 04 -> 00; pop order {0,1},{2,1},{0,0},{2,0}.
- Extended/unmapped: E0 75, E0 F0 75, 1C, F0 1C -> no events, held=00, FSM in P_IDLE; then 42 -> event {3,1}.
- Overflow with DEPTH=4, evt_ready=0: presses 23, 2B, 3B, 42, 5A -> count=4, overflow pulses on the 5A push, held=1F. Then one pop coinciding with a push of 76 -> count stays 4, no overflow.
- Timeout with TIMEOUT_CYCLES=16: byte F0, idle 16 cycles, then 23 -> treated as make: event {0,1}, held[0]=1. Repeat with only 10 idle cycles -> treated as break of an unheld key: no event. Also drive resetn=0 during P_BRK -> next 23 is a make.
